// File: rtl/rs_issue_controller.sv
// Reservation-station issue controller sequencing one per-FU dependency matrix.
// Define RS_AGE_SELECT_EN for oldest-first select; default selects the lowest ready row.
module rs_issue_controller #(
    parameter  int NUM_ROWS = 8,
    parameter  int TAG_W    = 6,
    localparam int IDX_W    = $clog2(NUM_ROWS),
    localparam int CNT_W    = $clog2(NUM_ROWS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic [NUM_ROWS-1:0] disp_deps,
    input  logic [TAG_W-1:0]    disp_tag,
    output logic                dm_w_en,
    output logic [IDX_W-1:0]    dm_w_row_index,
    output logic [NUM_ROWS-1:0] dm_set_lines,
    output logic                dm_clear_en,
    output logic [NUM_ROWS-1:0] dm_clear_lines,
    output logic                dm_free_en,
    output logic [IDX_W-1:0]    dm_free_row_index,
    input  logic [NUM_ROWS-1:0] dm_ready_vector,
    input  logic                flush,
    output logic                iss_valid,
    input  logic                iss_ready,
    output logic [TAG_W-1:0]    iss_tag,
    output logic [IDX_W-1:0]    iss_row,
    output logic [CNT_W-1:0]    occ_count
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t              state, next_state;
    logic [NUM_ROWS-1:0] occupied, occ_next, cand;
    logic [TAG_W-1:0]    tags [NUM_ROWS];
    logic [IDX_W-1:0]    flush_ptr, alloc_row, sel_row;
    logic                any_free, any_cand, run_active, accept, sel_fire, flush_free;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:   if (flush) next_state = FLUSH;
            FLUSH: if (occupied == '0 && !iss_valid) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        alloc_row = '0;
        any_free  = 1'b0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!occupied[i]) begin
                alloc_row = IDX_W'(i);
                any_free  = 1'b1;
            end
        end
    end

    assign cand = dm_ready_vector & occupied;

`ifdef RS_AGE_SELECT_EN
    // older[i][j] set means row i was allocated before row j
    logic [NUM_ROWS-1:0] older [NUM_ROWS];
    logic                blocked;

    always_comb begin
        sel_row  = '0;
        any_cand = 1'b0;
        blocked  = 1'b0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            blocked = 1'b0;
            for (int j = 0; j < NUM_ROWS; j++)
                if (cand[j] && older[j][i]) blocked = 1'b1;
            if (cand[i] && !blocked) begin
                sel_row  = IDX_W'(i);
                any_cand = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROWS; i++) older[i] <= '0;
        end else begin
            if (accept) begin
                for (int j = 0; j < NUM_ROWS; j++) begin
                    older[alloc_row][j] <= 1'b0;
                    older[j][alloc_row] <= occupied[j];
                end
            end
            if (dm_free_en) begin
                for (int j = 0; j < NUM_ROWS; j++) begin
                    older[dm_free_row_index][j] <= 1'b0;
                    older[j][dm_free_row_index] <= 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        sel_row  = '0;
        any_cand = 1'b0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_row  = IDX_W'(i);
                any_cand = 1'b1;
            end
        end
    end
`endif

    // A flush request suppresses dispatch and select in the cycle it arrives
    always_comb begin
        run_active        = (state == RUN) && !rst && !flush;
        disp_ready        = run_active && any_free;
        accept            = disp_valid && disp_ready;
        sel_fire          = run_active && any_cand && (!iss_valid || iss_ready);
        flush_free        = (state == FLUSH) && !rst && occupied[flush_ptr];
        dm_w_en           = accept;
        dm_w_row_index    = alloc_row;
        dm_free_en        = sel_fire || flush_free;
        dm_clear_en       = dm_free_en;
        dm_free_row_index = flush_free ? flush_ptr : sel_row;
        dm_clear_lines    = dm_free_en ? (NUM_ROWS'(1) << dm_free_row_index) : '0;
        dm_set_lines      = disp_deps & occupied & ~dm_clear_lines;
        occ_next          = (occupied | (accept ? (NUM_ROWS'(1) << alloc_row) : '0))
                            & ~dm_clear_lines;
    end

    always_comb begin
        occ_count = '0;
        for (int i = 0; i < NUM_ROWS; i++) occ_count = occ_count + CNT_W'(occupied[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupied  <= '0;
            iss_valid <= 1'b0;
            iss_tag   <= '0;
            iss_row   <= '0;
            flush_ptr <= '0;
            for (int i = 0; i < NUM_ROWS; i++) tags[i] <= '0;
        end else begin
            occupied <= occ_next;
            if (state == RUN && flush) begin
                iss_valid <= 1'b0;
                flush_ptr <= '0;
            end else if (state == RUN) begin
                if (sel_fire) begin
                    iss_valid <= 1'b1;
                    iss_tag   <= tags[sel_row];
                    iss_row   <= sel_row;
                end else if (iss_ready) begin
                    iss_valid <= 1'b0;
                end
                if (accept) tags[alloc_row] <= disp_tag;
            end else begin
                flush_ptr <= (flush_ptr == IDX_W'(NUM_ROWS - 1)) ? '0 : flush_ptr + 1'b1;
            end
        end
    end

endmodule
